store_commit_ctrl: RTL

- Commit-side sequencer for the store unit. Sits between the commit stage and the store unit's commit inputs.
- Issues plain-store commits to the store buffer. Serialises AMO commits behind store-buffer drain and holds the AMO commit until the response arrives.
- Resolves fences by waiting for all committed stores to drain.
- Reports handshakes back to the commit stage.

---
 rtl/store_commit_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/store_commit_ctrl.sv
// rtl/store_commit_ctrl.sv - commit-side sequencer for plain stores, AMOs and fences
// Optional stall watchdog is built when STORE_COMMIT_WDOG_EN is defined.
module store_commit_ctrl #(
  parameter int unsigned WDOG_CYCLES = 1024,
  parameter int unsigned WDOG_W      = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        st_commit_valid_i,
  output logic        st_commit_ack_o,
  input  logic        amo_commit_valid_i,
  output logic        amo_commit_ack_o,
  output logic [63:0] amo_result_o,
  input  logic        fence_valid_i,
  output logic        fence_done_o,
  output logic        commit_o,
  input  logic        commit_ready_i,
  input  logic        no_st_pending_i,
  output logic        amo_valid_commit_o,
  input  logic        amo_resp_ack_i,
  input  logic [63:0] amo_resp_result_i,
  output logic        busy_o,
  output logic [31:0] commit_cnt_o,
  output logic        wdog_err_o
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    AMO_DRAIN  = 3'd1,
    AMO_WAIT   = 3'd2,
    AMO_DONE   = 3'd3,
    FENCE_WAIT = 3'd4
  } state_e;

  state_e      state_q;
  logic [63:0] amo_result_q;
  logic [31:0] commit_cnt_q;
  logic        in_idle;
  logic        st_issue;
  logic        amo_take;
  logic        fence_take;
  logic        fence_fire;

  // Store and fence handshakes are zero-latency, so they are gated with reset
  // to keep every output low while reset is held.
  assign in_idle    = (state_q == IDLE);
  assign st_issue   = rst_ni && in_idle && st_commit_valid_i && commit_ready_i;
  assign amo_take   = in_idle && !st_commit_valid_i && amo_commit_valid_i;
  assign fence_take = in_idle && !st_commit_valid_i && !amo_commit_valid_i && fence_valid_i;
  assign fence_fire = rst_ni && (state_q == FENCE_WAIT) && no_st_pending_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      amo_result_q <= 64'd0;
      commit_cnt_q <= 32'd0;
    end else begin
      if (st_issue) begin
        commit_cnt_q <= commit_cnt_q + 32'd1;
      end
      unique case (state_q)
        IDLE: begin
          if (amo_take) begin
            state_q <= AMO_DRAIN;
          end else if (fence_take) begin
            state_q <= FENCE_WAIT;
          end
        end
        AMO_DRAIN: begin
          if (no_st_pending_i) begin
            state_q <= AMO_WAIT;
          end
        end
        AMO_WAIT: begin
          if (amo_resp_ack_i) begin
            amo_result_q <= amo_resp_result_i;
            state_q      <= AMO_DONE;
          end
        end
        AMO_DONE: begin
          state_q <= IDLE;
        end
        FENCE_WAIT: begin
          if (fence_fire) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign commit_o           = st_issue;
  assign st_commit_ack_o    = st_issue;
  assign fence_done_o       = fence_fire;
  assign amo_valid_commit_o = (state_q == AMO_WAIT);
  assign amo_commit_ack_o   = (state_q == AMO_DONE);
  assign busy_o             = !in_idle;
  assign amo_result_o       = amo_result_q;
  assign commit_cnt_o       = commit_cnt_q;

`ifdef STORE_COMMIT_WDOG_EN
  logic [WDOG_W-1:0] wdog_cnt_q;
  logic              wdog_err_q;

  // The counter parks at the limit so a long stall cannot wrap it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wdog_cnt_q <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      if (in_idle) begin
        wdog_cnt_q <= '0;
      end else if (wdog_cnt_q != WDOG_W'(WDOG_CYCLES)) begin
        wdog_cnt_q <= wdog_cnt_q + WDOG_W'(1);
      end
      if (wdog_cnt_q == WDOG_W'(WDOG_CYCLES)) begin
        wdog_err_q <= 1'b1;
      end
    end
  end

  assign wdog_err_o = wdog_err_q;
`else
  logic wdog_cfg_unused;
  assign wdog_cfg_unused = (WDOG_W'(WDOG_CYCLES) == '0);
  assign wdog_err_o      = 1'b0;
`endif

endmodule
